// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C command core between two requesters.
// The winner's command is latched at grant, issued for one cycle, then tracked to completion or start timeout.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [6:0] slave_addr0,
    input  logic [6:0] slave_addr1,
    input  logic [7:0] reg_addr0,
    input  logic [7:0] reg_addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rdata,
    input  logic       core_busy,
    input  logic [7:0] core_rdata,
    output logic       data_valid,
    output logic       rw,
    output logic [6:0] slave_addr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        FINISH     = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic       owner_q;
    logic       last_q;
    logic       pick;
    logic       grant_now;
    logic       timeout_now;
    logic       owned;
    logic       cmd_rw_q;
    logic [6:0] cmd_slave_q;
    logic [7:0] cmd_reg_q;
    logic [7:0] cmd_data_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_inc;
    logic       tout_q;

    // Handshake with the core: data_valid qualifies the command bus for a single
    // cycle; the core acknowledges by raising core_busy and finishes by dropping it.

    assign cnt_inc = 8'(cnt_q + 8'd1);

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_now   = 1'b0;
        timeout_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (!core_busy && (req0 || req1)) begin
                    grant_now = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (core_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    timeout_now = 1'b1;
                    state_d     = FINISH;
                end
            end
            WAIT_DONE: begin
                if (!core_busy) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cmd_rw_q    <= 1'b0;
            cmd_slave_q <= 7'd0;
            cmd_reg_q   <= 8'd0;
            cmd_data_q  <= 8'd0;
            cnt_q       <= 8'd0;
            tout_q      <= 1'b0;
            data_valid  <= 1'b0;
            rw          <= 1'b0;
            slave_addr  <= 7'd0;
            reg_addr    <= 8'd0;
            reg_data    <= 8'd0;
            rdata       <= 8'd0;
        end else begin
            data_valid <= (state_q == ISSUE);
            if (grant_now) begin
                owner_q     <= pick;
                tout_q      <= 1'b0;
                cmd_rw_q    <= pick ? rw1 : rw0;
                cmd_slave_q <= pick ? slave_addr1 : slave_addr0;
                cmd_reg_q   <= pick ? reg_addr1 : reg_addr0;
                cmd_data_q  <= pick ? wdata1 : wdata0;
            end
            // The bus only moves when the command is issued, so it holds between commands.
            if (state_q == ISSUE) begin
                rw         <= cmd_rw_q;
                slave_addr <= cmd_slave_q;
                reg_addr   <= cmd_reg_q;
                reg_data   <= cmd_data_q;
                cnt_q      <= 8'd0;
            end
            if (state_q == WAIT_START) begin
                cnt_q <= cnt_inc;
            end
            if (timeout_now) begin
                tout_q <= 1'b1;
            end
            if ((state_q == WAIT_DONE) && !core_busy) begin
                rdata <= core_rdata;
            end
            if (state_q == FINISH) begin
                last_q <= owner_q;
            end
        end
    end

    assign owned     = (state_q == ISSUE) || (state_q == WAIT_START) || (state_q == WAIT_DONE);
    assign gnt0      = owned && !owner_q;
    assign gnt1      = owned && owner_q;
    assign done0     = (state_q == FINISH) && !owner_q;
    assign done1     = (state_q == FINISH) && owner_q;
    assign err       = (state_q == FINISH) && tout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed scenarios plus randomized transactions against a
// behavioural round-robin model, with the bench acting as the I2C core.
module tb_i2c_arbiter;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic       req0, req1, rw0, rw1;
    logic [6:0] slave_addr0, slave_addr1;
    logic [7:0] reg_addr0, reg_addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rdata;
    logic       core_busy;
    logic [7:0] core_rdata;
    logic       data_valid, rw;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr, reg_data;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int overlap_errs = 0;
    int last_served = 1;
    logic [7:0] exp_rdata = 8'h00;
    logic [23:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .slave_addr0(slave_addr0), .slave_addr1(slave_addr1),
        .reg_addr0(reg_addr0), .reg_addr1(reg_addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .core_busy(core_busy), .core_rdata(core_rdata),
        .data_valid(data_valid), .rw(rw), .slave_addr(slave_addr),
        .reg_addr(reg_addr), .reg_data(reg_data), .state_dbg(state_dbg)
    );

    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (done0 && done1)) overlap_errs++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int pick_winner(input logic r0, input logic r1);
        if (r0 && r1) return (last_served == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [23:0] cmd_of(input int who);
        if (who == 1) return {rw1, slave_addr1, reg_addr1, wdata1};
        return {rw0, slave_addr0, reg_addr0, wdata0};
    endfunction

    function automatic logic [23:0] bus_now();
        return {rw, slave_addr, reg_addr, reg_data};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        rw0 = 1'($urandom_range(0, 1));
        rw1 = 1'($urandom_range(0, 1));
        slave_addr0 = 7'($urandom);
        slave_addr1 = 7'($urandom);
        reg_addr0 = 8'($urandom);
        reg_addr1 = 8'($urandom);
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                who = gnt1 ? 1 : 0;
                return;
            end
        end
    endtask

    task automatic serve(input int busy_len, input logic [7:0] rd);
        core_busy = 1'b1;
        core_rdata = ~rd;
        repeat (busy_len) tick();
        core_busy = 1'b0;
        core_rdata = rd;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; core_busy = 1'b0; core_rdata = 8'hFF;
        rand_fields();
        tick(); tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, err, data_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, done0, done1, err, data_valid});
        end
        checks++;
        if ({bus_now(), rdata} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00000000", {bus_now(), rdata});
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        last_served = 1; exp_rdata = 8'h00;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 00", {gnt0, gnt1});
        end
    endtask

    task automatic test_tie();
        int who, exp_who;
        logic [23:0] exp_cmd;
        logic [7:0] rd;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            exp_who = pick_winner(1'b1, 1'b1);
            exp_q.push_back(cmd_of(exp_who));
            wait_grant(who);
            checks++;
            if (who !== exp_who || who !== ((k == 1) ? 1 : 0)) begin
                failures++;
                $display("FAIL tie_winner[%0d]: got %0d expected %0d", k, who, exp_who);
            end
            if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            exp_cmd = exp_q.pop_front();
            checks++;
            if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
                failures++;
                $display("FAIL tie_cmd[%0d]: got dv=%b %h expected dv=1 %h", k, data_valid, bus_now(), exp_cmd);
            end
            rd = 8'($urandom);
            serve(2, rd);
            checks++;
            if ({done0, done1, err} !== ((exp_who == 0) ? 3'b100 : 3'b010) || rdata !== rd) begin
                failures++;
                $display("FAIL tie_done[%0d]: got %b rdata=%h expected owner %0d rdata=%h", k, {done0, done1, err}, rdata, exp_who, rd);
            end
            last_served = exp_who; exp_rdata = rd;
        end
        tick();
    endtask

    task automatic test_single();
        logic [23:0] exp_cmd;
        req0 = 1'b1; rw0 = 1'b0; slave_addr0 = 7'h66; reg_addr0 = 8'h32; wdata0 = 8'h33;
        exp_cmd = {1'b0, 7'h66, 8'h32, 8'h33};
        tick();
        checks++;
        if ({gnt0, gnt1, data_valid} !== 3'b100) begin
            failures++;
            $display("FAIL single_gnt: got gnt0/gnt1/dv=%b expected 100", {gnt0, gnt1, data_valid});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL single_cmd: got dv=%b %h expected dv=1 %h", data_valid, bus_now(), exp_cmd);
        end
        core_busy = 1'b1;
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_dv_width: got %b expected 0", data_valid);
        end
        repeat (9) tick();
        core_busy = 1'b0; core_rdata = 8'hA5;
        tick();
        checks++;
        if ({done0, done1, err, gnt0} !== 4'b1000 || rdata !== 8'hA5) begin
            failures++;
            $display("FAIL single_done: got done0/done1/err/gnt0=%b rdata=%h expected 1000 a5", {done0, done1, err, gnt0}, rdata);
        end
        last_served = 0; exp_rdata = 8'hA5;
        tick();
        checks++;
        if (done0 !== 1'b0 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL single_retain: got done0=%b bus=%h expected 0 %h", done0, bus_now(), exp_cmd);
        end
    endtask

    task automatic test_timeout();
        int who, early;
        logic [23:0] exp_cmd;
        rand_fields(); req1 = 1'b1;
        exp_cmd = cmd_of(1);
        core_rdata = ~exp_rdata;
        wait_grant(who);
        checks++;
        if (who !== pick_winner(1'b0, 1'b1)) begin
            failures++;
            $display("FAIL timeout_gnt: got %0d expected 1", who);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL timeout_cmd: got dv=%b %h expected dv=1 %h", data_valid, bus_now(), exp_cmd);
        end
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (done0 || done1 || err) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d early pulses expected 0", early);
        end
        tick();
        checks++;
        if ({done0, done1, err} !== 3'b011 || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL timeout_pulse: got %b rdata=%h expected 011 rdata=%h", {done0, done1, err}, rdata, exp_rdata);
        end
        last_served = 1;
        tick();
        checks++;
        if ({done1, err} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_one_cycle: got %b expected 00", {done1, err});
        end
    endtask

    task automatic test_busy_core();
        int early;
        logic [23:0] exp_cmd;
        logic [7:0] rd;
        rand_fields(); core_busy = 1'b1; req1 = 1'b1;
        exp_cmd = cmd_of(1);
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt0 || gnt1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL busy_no_grant: got %0d grant cycles expected 0", early);
        end
        core_busy = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL busy_release_gnt: got %b expected 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL busy_cmd: got dv=%b %h expected dv=1 %h", data_valid, bus_now(), exp_cmd);
        end
        rd = 8'($urandom);
        serve(3, rd);
        checks++;
        if ({done0, done1, err} !== 3'b010 || rdata !== rd) begin
            failures++;
            $display("FAIL busy_done: got %b rdata=%h expected 010 rdata=%h", {done0, done1, err}, rdata, rd);
        end
        last_served = 1; exp_rdata = rd;
        tick();
    endtask

    task automatic test_input_change();
        int who;
        logic [23:0] exp_cmd;
        logic [7:0] rd;
        rand_fields(); req0 = 1'b1;
        exp_cmd = cmd_of(0);
        wait_grant(who);
        checks++;
        if (who !== 0) begin
            failures++;
            $display("FAIL chg_gnt: got %0d expected 0", who);
        end
        wdata0 = ~wdata0; slave_addr0 = ~slave_addr0; rw0 = ~rw0;
        tick();
        checks++;
        if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL chg_issue_cmd: got dv=%b %h expected dv=1 %h", data_valid, bus_now(), exp_cmd);
        end
        wdata0 = wdata0 ^ 8'h5A; req0 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b0 || reg_data !== exp_cmd[7:0] || gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL chg_hold: got dv=%b reg_data=%h gnt0=%b expected 0 %h 1", data_valid, reg_data, gnt0, exp_cmd[7:0]);
        end
        rd = 8'($urandom);
        serve(2, rd);
        checks++;
        if ({done0, done1, err} !== 3'b100 || rdata !== rd || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL chg_done: got %b rdata=%h bus=%h expected 100 %h %h", {done0, done1, err}, rdata, bus_now(), rd, exp_cmd);
        end
        last_served = 0; exp_rdata = rd;
        tick(); tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL chg_no_regrant: got %b expected 00", {gnt0, gnt1});
        end
    endtask

    task automatic test_mid_reset();
        int who;
        logic [23:0] exp_cmd;
        logic [7:0] rd;
        rand_fields(); req0 = 1'b1;
        wait_grant(who);
        checks++;
        if (who !== 0) begin
            failures++;
            $display("FAIL mid_rst_gnt: got %0d expected 0", who);
        end
        tick();
        core_busy = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, err, data_valid} !== 6'b0 || {bus_now(), rdata} !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst_outputs: got %b %h expected 000000 00000000", {gnt0, gnt1, done0, done1, err, data_valid}, {bus_now(), rdata});
        end
        rst = 1'b0; core_busy = 1'b0;
        last_served = 1; exp_rdata = 8'h00;
        exp_cmd = cmd_of(pick_winner(1'b1, 1'b0));
        tick();
        checks++;
        if ({gnt0, gnt1, done0} !== 3'b100) begin
            failures++;
            $display("FAIL mid_rst_regrant: got gnt0/gnt1/done0=%b expected 100", {gnt0, gnt1, done0});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
            failures++;
            $display("FAIL mid_rst_cmd: got dv=%b %h expected dv=1 %h", data_valid, bus_now(), exp_cmd);
        end
        rd = 8'($urandom);
        serve(1, rd);
        checks++;
        if ({done0, done1, err} !== 3'b100 || rdata !== rd) begin
            failures++;
            $display("FAIL mid_rst_done: got %b rdata=%h expected 100 %h", {done0, done1, err}, rdata, rd);
        end
        last_served = 0; exp_rdata = rd;
        tick();
    endtask

    task automatic test_random();
        int who, exp_who, mode;
        logic r0, r1;
        logic [23:0] prev_bus, exp_cmd;
        logic [7:0] rd;
        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) begin
                if ($urandom_range(0, 1) == 0) r0 = 1'b1; else r1 = 1'b1;
            end
            rand_fields();
            req0 = r0; req1 = r1;
            exp_who = pick_winner(r0, r1);
            exp_q.push_back(cmd_of(exp_who));
            prev_bus = bus_now();
            wait_grant(who);
            checks++;
            if (who !== exp_who) begin
                failures++;
                $display("FAIL rand_winner[%0d]: got %0d expected %0d (req=%b%b)", n, who, exp_who, r1, r0);
            end
            checks++;
            if (bus_now() !== prev_bus || data_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_bus_hold[%0d]: got dv=%b %h expected dv=0 %h", n, data_valid, bus_now(), prev_bus);
            end
            if (exp_who == 0) req0 = 1'b0; else req1 = 1'b0;
            if ($urandom_range(0, 1) == 1) rand_fields();
            tick();
            exp_cmd = exp_q.pop_front();
            checks++;
            if (data_valid !== 1'b1 || bus_now() !== exp_cmd) begin
                failures++;
                $display("FAIL rand_cmd[%0d]: got dv=%b %h expected dv=1 %h", n, data_valid, bus_now(), exp_cmd);
            end
            mode = $urandom_range(0, 4);
            rd = 8'($urandom);
            if (mode == 0) begin
                core_rdata = rd;
                repeat (TO) tick();
            end else begin
                serve(mode, rd);
                exp_rdata = rd;
            end
            checks++;
            if ({done0, done1} !== ((exp_who == 0) ? 2'b10 : 2'b01) || err !== (mode == 0) ||
                rdata !== exp_rdata || {gnt0, gnt1} !== 2'b00) begin
                failures++;
                $display("FAIL rand_done[%0d]: got done=%b err=%b rdata=%h gnt=%b expected owner %0d err=%0d rdata=%h",
                         n, {done0, done1}, err, rdata, {gnt0, gnt1}, exp_who, (mode == 0), exp_rdata);
            end
            last_served = exp_who;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_timeout();
        test_busy_core();
        test_input_change();
        test_mid_reset();
        test_random();
        checks++;
        if (overlap_errs != 0) begin
            failures++;
            $display("FAIL exclusivity: got %0d overlapping cycles expected 0", overlap_errs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the cycles to wait for core_busy to rise after data_valid (legal range 1..255).
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req0, req1  in  1  requester N asks for one I2C transaction.
REQ-005 rw0, rw1  in  1  transaction direction of requester N, passed to the core unchanged.
REQ-006 slave_addr0, slave_addr1  in  7  target slave address of requester N.
REQ-007 reg_addr0, reg_addr1  in  8  target register address of requester N.
REQ-008 wdata0, wdata1  in  8  write data of requester N.
REQ-009 gnt0, gnt1  out  1  requester N owns the core, from grant until its done pulse.
REQ-010 done0, done1  out  1  one-cycle pulse marking the end of requester N's transaction.
REQ-011 err  out  1  one-cycle pulse, coincident with doneN, when the transaction timed out.
REQ-012 rdata  out  8  core_rdata captured at completion, held until the next completion.
REQ-013 core_busy  in  1  I2C core busy flag.
REQ-014 core_rdata  in  8  I2C core read data.
REQ-015 data_valid, rw, slave_addr(7), reg_addr(8), reg_data(8)  out  command bus to the I2C core.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_START, WAIT_DONE and FINISH.
REQ-017 IDLE: when core_busy=0 and req0 or req1 is high, the FSM SHALL select a winner, latch its rw, slave_addr, reg_addr and wdata into internal registers, assert gntN, and go to ISSUE.
REQ-018 IDLE: while core_busy=1, no grant SHALL be issued, even if requests are pending.
REQ-019 Arbitration SHALL be round-robin: a single requester wins outright; when both request, the requester not served last wins.
REQ-020 The last-served pointer SHALL update only in FINISH.
REQ-021 ISSUE: data_valid SHALL be 1 for exactly this one cycle, with the latched command stable on rw, slave_addr, reg_addr and reg_data; the next state SHALL be WAIT_START.
REQ-022 WAIT_START: an 8-bit counter, cleared on entry, SHALL increment each cycle.
REQ-023 WAIT_START: core_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-024 WAIT_START: when the counter reaches TIMEOUT with core_busy still 0, the FSM SHALL set a timeout flag and go to FINISH.
REQ-025 WAIT_DONE: core_busy=0 SHALL capture core_rdata into rdata and move the FSM to FINISH; there SHALL be no timeout in WAIT_DONE.
REQ-026 FINISH: doneN SHALL pulse for one cycle; err SHALL pulse in the same cycle if the timeout flag is set (rdata unchanged in that case).
REQ-027 FINISH: gntN SHALL drop in the same cycle as doneN, and the FSM SHALL return to IDLE.
REQ-028 Latency: a request arriving in IDLE with the core free gives gnt at edge+1 and data_valid at edge+2.
REQ-029 Command inputs SHALL be sampled only at grant; changes or a dropped reqN afterwards SHALL NOT abort or alter the transaction.
REQ-030 A requester still holding reqN after its done pulse SHALL be re-eligible in the next IDLE cycle, subject to round-robin.
REQ-031 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.
REQ-032 The command bus SHALL retain its last values outside ISSUE; only data_valid is qualifying.

Reset
REQ-033 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and gnt0, gnt1, done0, done1, err, data_valid, rw, slave_addr, reg_addr, reg_data, rdata, the counter and the timeout flag SHALL be 0; the last-served pointer SHALL be set to 1, so req0 wins the first tie.
REQ-034 Reset during any state SHALL abort the transaction with no done or err pulse, and data_valid SHALL be 0 from the next cycle.

Verification
REQ-035 Single request: req0=1, slave_addr0=7'h66, reg_addr0=8'h32, wdata0=8'h33, core idle -> gnt0 at edge+1; data_valid one cycle at edge+2 with 66/32/33; core busy 10 cycles then low, core_rdata=8'hA5 -> done0 pulse, rdata=A5, err=0.
REQ-036 Tie after reset: req0=req1=1 -> first grant to 0, second to 1, third to 0; no overlap of gnt0/gnt1 or done0/done1.
REQ-037 Timeout: TIMEOUT=4, core_busy held 0 after data_valid -> done1 and err pulse together 4 cycles after entering WAIT_START; rdata unchanged.
REQ-038 Busy core: core_busy=1 while req1=1 in IDLE -> no gnt until core_busy=0, then gnt1 next edge.
REQ-039 Mid-transaction reset: rst=1 in WAIT_DONE -> all outputs 0 next cycle, no done pulse; a held req0 is granted normally after rst drops.
REQ-040 Input change after grant: wdata0 changes and req0 drops in WAIT_START -> reg_data keeps the latched value and done0 still pulses.
